apb_completer: RTL

APB5 completer (responder) with an on-chip register bank, the target end of the APB requester transactions driven in the APB testbench and UVM environment. It decodes a word-aligned window of `NUM_REGS` 32-bit registers and inserts a programmable number of wait states. It supports byte strobes, protection checks and PSLVERR signalling. It sits behind `apb_inf` as the DUT slave for protocol-level verification.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_completer_if.sv | 28 ++
 rtl/apb_reg_bank.sv | 37 +++
 rtl/apb_completer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB completer: FSM states, default bus widths and
// the error-cause encoding used by decode and by scoreboards.
package apb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} apb_state_e;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_RANGE,
    ERR_ALIGN,
    ERR_RO,
    ERR_PRIV,
    ERR_STRB
  } apb_err_e;

endpackage

// File: rtl/apb_completer_if.sv
// APB5 bus bundle between a requester (master) and the completer (slave).
interface apb_completer_if
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [2:0]              pprot;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_reg_bank.sv
// Register array with a byte-strobed write port and a combinational read port;
// register 0 reads a fixed ID and read-only registers ignore writes.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = 'h01,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 'hA9B5_0001,
  localparam int                   IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int                   STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0]     strb,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && !RO_MASK[wr_idx]) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (strb[k]) regs[wr_idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = (rd_idx == '0) ? ID_VALUE : regs[rd_idx];

endmodule

// File: rtl/apb_completer.sv
// APB5 completer: setup capture, decode/error checks, wait-state FSM and
// registered response outputs in front of apb_reg_bank.
module apb_completer
  import apb_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int                    NUM_REGS    = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h80,
  parameter int                    WAIT_STATES = 1,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = 'h01,
  parameter logic [NUM_REGS-1:0]   PRIV_MASK   = 'h80,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 'hA9B5_0001
) (
  input  logic          pclk,
  input  logic          preset,
  apb_completer_if.slave bus
);

  localparam int                  STRB_W   = DATA_WIDTH / 8;
  localparam int                  IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0]          WS       = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH:0] END_ADDR = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(4 * NUM_REGS);

  apb_state_e            state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic                  cap_en;
  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      dec_idx;
  apb_err_e              dec_cause;
  logic                  dec_err;

  logic [IDX_W-1:0]      cap_idx;
  logic                  cap_write;
  logic                  cap_err;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [STRB_W-1:0]     cap_strb;

  logic [IDX_W-1:0]      cur_idx;
  logic                  cur_write;
  logic                  cur_err;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  we;

  logic                  pready_q;
  logic                  pslverr_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  unused_prot;

  assign unused_prot = ^bus.pprot[2:1];

  always_comb begin
    offset    = bus.paddr - BASE_ADDR;
    dec_idx   = IDX_W'(offset >> 2);
    dec_cause = ERR_NONE;
    if (({1'b0, bus.paddr} < {1'b0, BASE_ADDR}) || ({1'b0, bus.paddr} >= END_ADDR))
      dec_cause = ERR_RANGE;
    else if (bus.paddr[1:0] != 2'b00)
      dec_cause = ERR_ALIGN;
    else if (bus.pwrite && RO_MASK[dec_idx])
      dec_cause = ERR_RO;
    else if (PRIV_MASK[dec_idx] && !bus.pprot[0])
      dec_cause = ERR_PRIV;
    else if (!bus.pwrite && (bus.pstrb != '0))
      dec_cause = ERR_STRB;
    dec_err = (dec_cause != ERR_NONE);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap_en  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          cap_en  = 1'b1;
          cnt_n   = WS;
          state_n = (WS == 4'd0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (!bus.psel) begin
          state_n = IDLE;
        end else if (bus.penable) begin
          if (cnt <= 4'd1) state_n = DONE;
          else             cnt_n   = cnt - 4'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // With zero wait states DONE is entered on the setup edge itself, so the
  // response must be formed from the live decode rather than the capture.
  assign cur_idx   = cap_en ? dec_idx     : cap_idx;
  assign cur_write = cap_en ? bus.pwrite  : cap_write;
  assign cur_err   = cap_en ? dec_err     : cap_err;
  assign we        = (state == DONE) && cap_write && !cap_err;

  always_ff @(posedge pclk) begin
    if (cap_en) begin
      cap_idx   <= dec_idx;
      cap_write <= bus.pwrite;
      cap_err   <= dec_err;
      cap_wdata <= bus.pwdata;
      cap_strb  <= bus.pstrb;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pready_q  <= (state_n == DONE);
      pslverr_q <= (state_n == DONE) && cur_err;
      prdata_q  <= ((state_n == DONE) && !cur_err && !cur_write) ? rd_data : '0;
    end
  end

  apb_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK),
    .ID_VALUE   (ID_VALUE)
  ) u_bank (
    .clk    (pclk),
    .rst    (preset),
    .we     (we),
    .wr_idx (cap_idx),
    .wdata  (cap_wdata),
    .strb   (cap_strb),
    .rd_idx (cur_idx),
    .rdata  (rd_data)
  );

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;

endmodule
